// File: rtl/fft_stream_io.sv
// Streaming front-end for the banked radix-4 FFT core: bank-interleaved frame
// load, core start/done handshake, and back-pressured result readout.
module fft_stream_io #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 17,
  parameter int N_LOG4 = 5,
  parameter int BANKS  = 4,
  parameter int ADDR_W = ((4 ** N_LOG4) / BANKS > 1) ? $clog2((4 ** N_LOG4) / BANKS) : 1,
  parameter int RD_LAT = 2
) (
  input  logic                    iCLK,
  input  logic                    iRESET,
  input  logic [DATA_W-1:0]       iS_DATA,
  input  logic                    iS_VALID,
  output logic                    oS_READY,
  input  logic                    iNAT_ORDER,
  output logic [ADDR_W-1:0]       oWR_ADDR,
  output logic [DATA_W-1:0]       oWR_DATA,
  output logic [BANKS-1:0]        oWE,
  output logic                    oCORE_START,
  input  logic                    iCORE_RDY,
  output logic [BANKS*ADDR_W-1:0] oRD_ADDR,
  input  logic [BANKS*OUT_W-1:0]  iRD_DATA,
  output logic [OUT_W-1:0]        oM_DATA,
  output logic                    oM_VALID,
  input  logic                    iM_READY,
  output logic                    oM_LAST,
  output logic                    oBUSY
);
  localparam int N      = 4 ** N_LOG4;
  localparam int IDX_W  = 2 * N_LOG4;
  localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int DEPTH  = RD_LAT + 2;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, UNLOAD} state_t;

  state_t            state;
  logic              s_ready, nat, core_start, rdy_q, rdy_edge, rd_done;
  logic [IDX_W-1:0]  n_cnt, rd_k, out_k, s_idx;
  logic [ADDR_W-1:0] wr_addr, rd_a;
  logic [DATA_W-1:0] wr_data;
  logic [BANKS-1:0]  we;
  logic [BANK_W-1:0] wr_bank, rd_bank;
  logic [ADDR_W-1:0] rd_addr [BANKS];
  // Stage 0 shadows the registered read address; stage RD_LAT lines up with iRD_DATA.
  logic              pipe_v [RD_LAT+1];
  logic [BANK_W-1:0] pipe_b [RD_LAT+1];
  logic [OUT_W-1:0]  fifo [DEPTH];
  logic [PTR_W-1:0]  wp, rp;
  logic [CNT_W-1:0]  occ;
  logic              accept, m_valid, pop, push, room, issue;
  logic [OUT_W-1:0]  push_data;
  int                inflight;

  function automatic logic [IDX_W-1:0] rev4(input logic [IDX_W-1:0] k);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < N_LOG4; i++)
      r[2*(N_LOG4-1-i) +: 2] = k[2*i +: 2];
    return r;
  endfunction

  always_comb begin
    inflight = 0;
    for (int unsigned i = 0; i <= RD_LAT; i++)
      if (pipe_v[i]) inflight = inflight + 1;
  end

  assign accept    = iS_VALID && s_ready;
  assign m_valid   = (occ != '0);
  assign pop       = m_valid && iM_READY;
  assign push      = pipe_v[RD_LAT];
  assign push_data = iRD_DATA[pipe_b[RD_LAT]*OUT_W +: OUT_W];
  // A word popped this cycle frees its slot in time for the read issued now.
  assign room      = (inflight + int'(occ)) < (DEPTH + int'(pop));
  assign issue     = ((state == WAIT && rdy_edge) || (state == UNLOAD && !rd_done)) && room;
  assign s_idx     = nat ? rev4(rd_k) : rd_k;
  assign rd_bank   = BANK_W'(s_idx % BANKS);
  assign rd_a      = ADDR_W'(s_idx / BANKS);
  assign wr_bank   = BANK_W'(n_cnt % BANKS);

  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      state <= IDLE;
      s_ready <= 1'b0; nat <= 1'b0; core_start <= 1'b0;
      rdy_q <= 1'b0; rdy_edge <= 1'b0; rd_done <= 1'b0;
      n_cnt <= '0; rd_k <= '0; out_k <= '0;
      wr_addr <= '0; wr_data <= '0; we <= '0;
      wp <= '0; rp <= '0; occ <= '0;
      for (int unsigned b = 0; b < BANKS; b++) rd_addr[b] <= '0;
      for (int unsigned i = 0; i <= RD_LAT; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_b[i] <= '0;
      end
      for (int unsigned i = 0; i < DEPTH; i++) fifo[i] <= '0;
    end else begin
      we         <= '0;
      core_start <= 1'b0;
      rdy_q      <= iCORE_RDY;
      rdy_edge   <= (state == WAIT) && iCORE_RDY && !rdy_q;

      pipe_v[0] <= issue;
      pipe_b[0] <= rd_bank;
      for (int unsigned i = 1; i <= RD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_b[i] <= pipe_b[i-1];
      end
      if (issue) begin
        rd_addr[rd_bank] <= rd_a;
        rd_k <= rd_k + 1'b1;
        if (rd_k == IDX_W'(N-1)) rd_done <= 1'b1;
      end

      if (push) begin
        fifo[wp] <= push_data;
        wp <= (wp == PTR_W'(DEPTH-1)) ? '0 : wp + 1'b1;
      end
      if (pop) rp <= (rp == PTR_W'(DEPTH-1)) ? '0 : rp + 1'b1;
      occ <= occ + CNT_W'(push) - CNT_W'(pop);

      unique case (state)
        IDLE, LOAD: begin
          s_ready <= 1'b1;
          if (accept) begin
            if (state == IDLE) nat <= iNAT_ORDER;
            wr_addr <= ADDR_W'(n_cnt / BANKS);
            wr_data <= iS_DATA;
            we      <= BANKS'(1) << wr_bank;
            n_cnt   <= n_cnt + 1'b1;
            state   <= LOAD;
            if (n_cnt == IDX_W'(N-1)) begin
              s_ready <= 1'b0;
              state   <= START;
            end
          end
        end
        START: begin
          core_start <= 1'b1;
          state      <= WAIT;
        end
        WAIT: if (rdy_edge) state <= UNLOAD;
        UNLOAD: begin
          if (pop) begin
            out_k <= out_k + 1'b1;
            if (out_k == IDX_W'(N-1)) begin
              state   <= IDLE;
              s_ready <= 1'b1;
              out_k   <= '0;
              rd_k    <= '0;
              rd_done <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    oRD_ADDR = '0;
    for (int unsigned b = 0; b < BANKS; b++)
      oRD_ADDR[b*ADDR_W +: ADDR_W] = rd_addr[b];
  end

  assign oS_READY    = s_ready;
  assign oWR_ADDR    = wr_addr;
  assign oWR_DATA    = wr_data;
  assign oWE         = we;
  assign oCORE_START = core_start;
  assign oM_VALID    = m_valid;
  assign oM_DATA     = fifo[rp];
  assign oM_LAST     = m_valid && (out_k == IDX_W'(N-1));
  assign oBUSY       = (state != IDLE);
endmodule
